// File: rtl/decd_nm_seq_pkg.sv
// Shared definitions for the N-to-2^N decoder/sequencer: mode codes, FSM states, decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package decd_nm_seq_pkg;

    // mode input encoding
    localparam logic [1:0] MODE_DEC    = 2'b00;
    localparam logic [1:0] MODE_THERMO = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Widest supported decoder: SEL_W = 6 -> 64 output lines.
    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // One bit set at position sel.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        return 64'd1 << sel;
    endfunction

    // Bits 0..sel set. For sel = 63 the shift overflows to zero and the
    // subtraction wraps to all ones, which is the intended full-scale value.
    function automatic logic [MAX_OUT_W-1:0] thermo(input logic [MAX_SEL_W-1:0] sel);
        return (64'd2 << sel) - 64'd1;
    endfunction

endpackage

// File: rtl/decd_nm_seq_if.sv
// Handshake and decoded-output bundle between a control block and decd_nm_seq.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the decoder gates in_valid; outputs are never stalled.
interface decd_nm_seq_if #(
    parameter int SEL_W = 3
) ();
    localparam int OUT_W = 2**SEL_W;

    logic             en;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [OUT_W-1:0] out_dec;
    logic             out_valid;
    logic             scan_wrap;
    logic             busy;

    // master: the controller driving codes into the decoder
    modport master (
        output en, mode, in_valid, in_sel,
        input  in_ready, out_dec, out_valid, scan_wrap, busy
    );

    // slave: the decoder itself
    modport slave (
        input  en, mode, in_valid, in_sel,
        output in_ready, out_dec, out_valid, scan_wrap, busy
    );
endinterface

// File: rtl/decd_nm_seq_core.sv
// Combinational SEL_W -> 2**SEL_W decoder, one-hot or thermometer per thermo_en.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module decd_nm_seq_core
    import decd_nm_seq_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic                 thermo_en,
    output logic [2**SEL_W-1:0]  dec
);
    localparam int OUT_W = 2**SEL_W;

    logic [MAX_SEL_W-1:0] sel_ext;
    logic [MAX_OUT_W-1:0] full;

    always_comb begin
        sel_ext              = '0;
        sel_ext[SEL_W-1:0]   = sel;
        full                 = thermo_en ? thermo(sel_ext) : onehot(sel_ext);
    end

    assign dec = full[OUT_W-1:0];

    // Lines above OUT_W are always zero for narrow decoders and are dropped.
    generate
        if (OUT_W < MAX_OUT_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^full[MAX_OUT_W-1:OUT_W];
        end
    endgenerate
endmodule

// File: rtl/decd_nm_seq.sv
// Registered N-to-2^N decoder with DECODE / THERMO / auto-SCAN modes and programmable dwell.
// Latency: accepted code on out_dec 1 cycle after the accepting edge, flagged by out_valid.
// Backpressure: in_ready (combinational) low while scanning, disabled, or in reserved mode.
//
// Ports: clk, rst_n (async active-low), bus (decd_nm_seq_if.slave):
//   en, mode, in_valid, in_sel -> in; in_ready, out_dec, out_valid, scan_wrap, busy -> out.
module decd_nm_seq
    import decd_nm_seq_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    decd_nm_seq_if.slave  bus
);
    localparam int OUT_W = 2**SEL_W;
    localparam int DW    = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic [DW-1:0]    dwell_cnt;
    logic [OUT_W-1:0] out_reg;     // active-high internally; polarity fixed at the port
    logic             out_valid_r;
    logic             scan_wrap_r;

    logic             enabled;
    logic             accept;
    logic [SEL_W-1:0] idx_nxt;
    logic [OUT_W-1:0] acc_dec;
    logic [OUT_W-1:0] step_dec;

    // Reserved mode behaves exactly like en = 0.
    assign enabled      = bus.en & (bus.mode != MODE_RSVD);
    assign bus.in_ready = enabled & (state != SCAN);
    assign accept       = bus.in_valid & bus.in_ready;
    assign idx_nxt      = idx + SEL_W'(1);

    // Decode of the incoming code; mode SCAN is not THERMO so this yields
    // the one-hot start line for a scan accept as well.
    decd_nm_seq_core #(.SEL_W(SEL_W)) u_acc_dec (
        .sel       (bus.in_sel),
        .thermo_en (bus.mode == MODE_THERMO),
        .dec       (acc_dec)
    );

    // Next scan line.
    decd_nm_seq_core #(.SEL_W(SEL_W)) u_step_dec (
        .sel       (idx_nxt),
        .thermo_en (1'b0),
        .dec       (step_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            dwell_cnt   <= '0;
            out_reg     <= '0;
            out_valid_r <= 1'b0;
            scan_wrap_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            scan_wrap_r <= 1'b0;
            if (!enabled) begin
                // Silent drop to inactive: no out_valid pulse.
                state     <= IDLE;
                idx       <= '0;
                dwell_cnt <= '0;
                out_reg   <= '0;
            end else begin
                case (state)
                    IDLE, HOLD: begin
                        // Without an accept the output and state hold, even if mode changed.
                        if (accept) begin
                            out_reg     <= acc_dec;
                            out_valid_r <= 1'b1;
                            if (bus.mode == MODE_SCAN) begin
                                state     <= SCAN;
                                idx       <= bus.in_sel;
                                dwell_cnt <= '0;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                    SCAN: begin
                        if (bus.mode != MODE_SCAN) begin
                            state     <= IDLE;
                            idx       <= '0;
                            dwell_cnt <= '0;
                            out_reg   <= '0;
                        end else if (dwell_cnt == DWELL_LAST) begin
                            idx         <= idx_nxt;
                            dwell_cnt   <= '0;
                            out_reg     <= step_dec;
                            out_valid_r <= 1'b1;
                            scan_wrap_r <= (idx == SEL_W'(OUT_W - 1));
                        end else begin
                            dwell_cnt <= dwell_cnt + DW'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        idx       <= '0;
                        dwell_cnt <= '0;
                        out_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.out_dec   = ACT_LOW ? ~out_reg : out_reg;
    assign bus.out_valid = out_valid_r;
    assign bus.scan_wrap = scan_wrap_r;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_decd_nm_seq.sv
// Directed bench for decd_nm_seq: scoreboard queue fed by stimulus, drained by an out_valid monitor.
// u0: SEL_W=3, DWELL=2, active-high. u1: SEL_W=2, DWELL=2, active-low.
module tb_decd_nm_seq;
    logic clk;
    logic rst_n;

    decd_nm_seq_if #(.SEL_W(3)) if0 ();
    decd_nm_seq_if #(.SEL_W(2)) if1 ();

    decd_nm_seq #(.SEL_W(3), .DWELL(2), .ACT_LOW(1'b0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    decd_nm_seq #(.SEL_W(2), .DWELL(2), .ACT_LOW(1'b1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] dec;
        logic       wrap;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic w);
        exp_t e;
        e.dec  = d;
        e.wrap = w;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid pulse on u0 must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(if0.out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_out_dec", 64'(if0.out_dec), 64'(e.dec));
                    chk("sb_scan_wrap", 64'(if0.scan_wrap), 64'(e.wrap));
                end
            end else begin
                chk("wrap_without_valid", 64'(if0.scan_wrap), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        if0.en = 1'b0; if0.mode = 2'b00; if0.in_valid = 1'b0; if0.in_sel = '0;
        if1.en = 1'b0; if1.mode = 2'b00; if1.in_valid = 1'b0; if1.in_sel = '0;
        repeat (2) step();
        #2;
        chk("rst_out_dec", 64'(if0.out_dec), 64'h00);
        chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_scan_wrap", 64'(if0.scan_wrap), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_actlow_out_dec", 64'(if1.out_dec), 64'hF);
        rst_n = 1'b1;
        step();

        // Active-low narrow decoder
        if1.en = 1'b1; if1.mode = 2'b00; if1.in_sel = 2'd1; if1.in_valid = 1'b1;
        step();
        chk("actlow_dec_sel1", 64'(if1.out_dec), 64'hD);
        chk("actlow_valid", 64'(if1.out_valid), 64'd1);
        if1.mode = 2'b01; if1.in_sel = 2'd2;
        step();
        chk("actlow_thermo_sel2", 64'(if1.out_dec), 64'h8);
        if1.in_valid = 1'b0; if1.en = 1'b0;
        step();
        chk("actlow_disable_inactive", 64'(if1.out_dec), 64'hF);
        chk("actlow_disable_busy", 64'(if1.busy), 64'd0);

        // DECODE sel=5, then hold
        if0.en = 1'b1; if0.mode = 2'b00; if0.in_sel = 3'd5; if0.in_valid = 1'b1;
        push(8'h20, 1'b0);
        step();
        if0.in_valid = 1'b0;
        step();
        chk("dec_hold", 64'(if0.out_dec), 64'h20);
        chk("dec_hold_no_valid", 64'(if0.out_valid), 64'd0);
        chk("dec_busy", 64'(if0.busy), 64'd1);

        // THERMO back-to-back
        if0.mode = 2'b01; if0.in_sel = 3'd2; if0.in_valid = 1'b1;
        push(8'h07, 1'b0);
        step();
        chk("thermo_sel2", 64'(if0.out_dec), 64'h07);
        if0.in_sel = 3'd7;
        push(8'hFF, 1'b0);
        step();
        chk("thermo_sel7", 64'(if0.out_dec), 64'hFF);
        if0.in_valid = 1'b0;
        step();

        // Mode change in HOLD without accept keeps the old value
        if0.mode = 2'b00;
        step();
        chk("hold_mode_dec", 64'(if0.out_dec), 64'hFF);
        if0.mode = 2'b10;
        step();
        chk("hold_mode_scan", 64'(if0.out_dec), 64'hFF);
        chk("hold_mode_scan_busy", 64'(if0.busy), 64'd1);

        // SCAN from sel=6: 40,40,80,80,01,01,02
        if0.in_sel = 3'd6; if0.in_valid = 1'b1;
        push(8'h40, 1'b0);
        step();
        chk("scan_start", 64'(if0.out_dec), 64'h40);
        chk("scan_ready0", 64'(if0.in_ready), 64'd0);
        push(8'h80, 1'b0);
        push(8'h01, 1'b1);
        push(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("scan_ready_low", 64'(if0.in_ready), 64'd0);
        end
        chk("scan_at_02", 64'(if0.out_dec), 64'h02);

        // Drop en during SCAN
        if0.en = 1'b0;
        #1;
        chk("en_low_ready", 64'(if0.in_ready), 64'd0);
        step();
        chk("en_low_out", 64'(if0.out_dec), 64'h00);
        chk("en_low_busy", 64'(if0.busy), 64'd0);
        if0.en = 1'b1; if0.mode = 2'b00; if0.in_sel = 3'd3;
        #1;
        chk("idle_ready", 64'(if0.in_ready), 64'd1);
        push(8'h08, 1'b0);
        step();
        chk("after_idle_accept", 64'(if0.out_dec), 64'h08);

        // Mode change out of SCAN with in_valid held high
        if0.mode = 2'b10; if0.in_sel = 3'd1;
        push(8'h02, 1'b0);
        step();
        if0.mode = 2'b00; if0.in_sel = 3'd4;
        #1;
        chk("scan_ignores_valid", 64'(if0.in_ready), 64'd0);
        step();
        chk("scan_exit_out", 64'(if0.out_dec), 64'h00);
        chk("scan_exit_busy", 64'(if0.busy), 64'd0);
        chk("scan_exit_ready", 64'(if0.in_ready), 64'd1);
        push(8'h10, 1'b0);
        step();
        chk("scan_exit_accept", 64'(if0.out_dec), 64'h10);
        if0.in_valid = 1'b0;
        step();

        // Async reset mid-dwell, then SCAN restart from new sel
        if0.mode = 2'b10; if0.in_sel = 3'd0; if0.in_valid = 1'b1;
        push(8'h01, 1'b0);
        step();
        if0.in_valid = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #2;
        chk("async_rst_out", 64'(if0.out_dec), 64'h00);
        chk("async_rst_busy", 64'(if0.busy), 64'd0);
        chk("async_rst_valid", 64'(if0.out_valid), 64'd0);
        if0.in_sel = 3'd3; if0.in_valid = 1'b1;
        step();
        rst_n = 1'b1;
        push(8'h08, 1'b0);
        push(8'h10, 1'b0);
        step();
        chk("restart_scan", 64'(if0.out_dec), 64'h08);
        if0.in_valid = 1'b0;
        step();
        chk("restart_dwell", 64'(if0.out_dec), 64'h08);
        step();
        chk("restart_step", 64'(if0.out_dec), 64'h10);
        if0.en = 1'b0;
        repeat (2) step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
